// File: rtl/bcd_mod_counter_if.sv
// rtl/bcd_mod_counter_if.sv - control and digit bundle for the two-digit BCD modulo counter
//
// Signals:
//   enable     count tick qualifier (one step per enabled cycle)
//   up_down    direction, 1 = up, 0 = down (down honoured only with COUNTER_DOWN_EN)
//   load       parallel load strobe
//   load_tens  BCD tens digit to load
//   load_ones  BCD ones digit to load
//   tens/ones  registered BCD value
//   carry_out  registered one-cycle wrap/borrow pulse
//   terminal   combinational "next enabled step wraps" decode
//   load_err   registered one-cycle out-of-range load pulse
// Modports: master drives the controls, slave is the counter.

interface bcd_mod_counter_if;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       carry_out;
    logic       terminal;
    logic       load_err;

    modport master (
        output enable, up_down, load, load_tens, load_ones,
        input  tens, ones, carry_out, terminal, load_err
    );

    modport slave (
        input  enable, up_down, load, load_tens, load_ones,
        output tens, ones, carry_out, terminal, load_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - parametrised two-digit BCD modulo-N counter with load and cascade pulse
//
// Optional feature macro: COUNTER_DOWN_EN (honour bus.up_down for down-counting with borrow).
//
// Parameters:
//   MODULUS     count modulus, 2..100; value runs 0..MODULUS-1
//   LOAD_CLAMP  1 = out-of-range load saturates to MODULUS-1, 0 = out-of-range load is ignored
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      bcd_mod_counter_if.slave (controls in, digits/pulses out)

module bcd_mod_counter #(
    parameter int MODULUS    = 60,
    parameter bit LOAD_CLAMP = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bcd_mod_counter_if.slave      bus
);

    generate
        if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
            $error("bcd_mod_counter: MODULUS must be in 2..100");
        end
    endgenerate

    // Top legal value split into digits so every range check is a per-digit compare.
    localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_carry;
    logic       r_load_err;

    logic [3:0] w_next_tens;
    logic [3:0] w_next_ones;
    logic       w_next_carry;
    logic       w_next_err;
    logic       w_down;
    logic       w_at_max;
    logic       w_at_zero;
    logic       w_load_ok;

`ifdef COUNTER_DOWN_EN
    assign w_down = ~bus.up_down;
`else
    logic w_unused_up_down;
    assign w_unused_up_down = bus.up_down;
    assign w_down           = 1'b0;
`endif

    assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

    // Both digits must be BCD, then the pair must sit at or below MAX_TENS:MAX_ONES.
    assign w_load_ok = (bus.load_ones <= 4'd9) && (bus.load_tens <= 4'd9) &&
                       ((bus.load_tens < MAX_TENS) ||
                        ((bus.load_tens == MAX_TENS) && (bus.load_ones <= MAX_ONES)));

    always_comb begin
        w_next_tens  = r_tens;
        w_next_ones  = r_ones;
        w_next_carry = 1'b0;
        w_next_err   = 1'b0;
        if (bus.load) begin
            // A load always wins over a tick and never produces carry_out.
            if (w_load_ok) begin
                w_next_tens = bus.load_tens;
                w_next_ones = bus.load_ones;
            end else begin
                w_next_err = 1'b1;
                if (LOAD_CLAMP) begin
                    w_next_tens = MAX_TENS;
                    w_next_ones = MAX_ONES;
                end
            end
        end else if (bus.enable) begin
            if (w_down) begin
                if (w_at_zero) begin
                    w_next_tens  = MAX_TENS;
                    w_next_ones  = MAX_ONES;
                    w_next_carry = 1'b1;
                end else if (r_ones != 4'd0) begin
                    w_next_ones = r_ones - 4'd1;
                end else begin
                    w_next_ones = 4'd9;
                    w_next_tens = r_tens - 4'd1;
                end
            end else begin
                if (w_at_max) begin
                    w_next_tens  = 4'd0;
                    w_next_ones  = 4'd0;
                    w_next_carry = 1'b1;
                end else if (r_ones == 4'd9) begin
                    w_next_ones = 4'd0;
                    w_next_tens = r_tens + 4'd1;
                end else begin
                    w_next_ones = r_ones + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tens     <= w_next_tens;
            r_ones     <= w_next_ones;
            r_carry    <= w_next_carry;
            r_load_err <= w_next_err;
        end
    end

    assign bus.tens      = r_tens;
    assign bus.ones      = r_ones;
    assign bus.carry_out = r_carry;
    assign bus.load_err  = r_load_err;
    // Enable-independent so a cascade can look ahead at the wrap.
    assign bus.terminal  = w_down ? w_at_zero : w_at_max;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - randomized self-checking bench for bcd_mod_counter over several moduli

module tb_bcd_mod_counter;

`ifdef COUNTER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    localparam int NDUT = 5;
    localparam int MODS   [NDUT] = '{60, 60, 24, 12, 2};
    localparam bit CLAMPS [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_en = 1'b0;
    logic       s_ud = 1'b1;
    logic       s_ld = 1'b0;
    logic [3:0] s_lt = 4'd0;
    logic [3:0] s_lo = 4'd0;

    logic [3:0] d_tens  [NDUT];
    logic [3:0] d_ones  [NDUT];
    logic       d_carry [NDUT];
    logic       d_term  [NDUT];
    logic       d_err   [NDUT];

    int   mv        [NDUT];
    bit   mc        [NDUT];
    bit   me        [NDUT];
    bit   exp_term  [NDUT];
    logic snap_term [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            bcd_mod_counter_if u_if ();
            assign u_if.enable    = s_en;
            assign u_if.up_down   = s_ud;
            assign u_if.load      = s_ld;
            assign u_if.load_tens = s_lt;
            assign u_if.load_ones = s_lo;
            bcd_mod_counter #(.MODULUS(MODS[g]), .LOAD_CLAMP(CLAMPS[g])) u_dut (
                .clock   (clock),
                .reset_n (reset_n),
                .bus     (u_if.slave)
            );
            assign d_tens[g]  = u_if.tens;
            assign d_ones[g]  = u_if.ones;
            assign d_carry[g] = u_if.carry_out;
            assign d_term[g]  = u_if.terminal;
            assign d_err[g]   = u_if.load_err;
        end
    endgenerate

    // Drive one cycle of stimulus, snapshot terminal before the edge, and advance the reference model.
    task automatic step(input bit e, input bit u, input bit l, input logic [3:0] t, input logic [3:0] o);
        s_en = e; s_ud = u; s_ld = l; s_lt = t; s_lo = o;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            snap_term[k] = d_term[k];
            exp_term[k]  = (DOWN_EN && !u) ? (mv[k] == 0) : (mv[k] == MODS[k] - 1);
        end
        for (int k = 0; k < NDUT; k++) begin
            int  nv;
            bit  c;
            bit  er;
            nv = mv[k]; c = 1'b0; er = 1'b0;
            if (l) begin
                if (o <= 9 && t <= 9 && (int'(t) * 10 + int'(o)) < MODS[k]) nv = int'(t) * 10 + int'(o);
                else begin
                    er = 1'b1;
                    if (CLAMPS[k]) nv = MODS[k] - 1;
                end
            end else if (e) begin
                if (DOWN_EN && !u) begin
                    c  = (mv[k] == 0);
                    nv = c ? MODS[k] - 1 : mv[k] - 1;
                end else begin
                    c  = (mv[k] == MODS[k] - 1);
                    nv = (mv[k] + 1) % MODS[k];
                end
            end
            mv[k] = nv; mc[k] = c; me[k] = er;
        end
        @(posedge clock);
        #1;
        s_en = 1'b0; s_ld = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (d_tens[k] !== 4'd0 || d_ones[k] !== 4'd0 || d_carry[k] !== 1'b0 || d_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_init dut%0d: got %0d/%0d c%0b e%0b want 0/0 c0 e0",
                         k, d_tens[k], d_ones[k], d_carry[k], d_err[k]);
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k < NDUT; k++) begin mv[k] = 0; mc[k] = 0; me[k] = 0; end
        step(1'b0, 1'b1, 1'b1, 4'd3, 4'd6);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                bad++;
                $display("FAIL count_37 dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                         k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
            end
        end
        // Asynchronous assert between edges: outputs must clear without a clock edge.
        reset_n = 1'b0;
        #2;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (d_tens[k] !== 4'd0 || d_ones[k] !== 4'd0 || d_carry[k] !== 1'b0 || d_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_async dut%0d: got %0d/%0d c%0b e%0b want 0/0 c0 e0",
                         k, d_tens[k], d_ones[k], d_carry[k], d_err[k]);
            end
            mv[k] = 0; mc[k] = 0; me[k] = 0;
        end
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        step(1'b0, 1'b1, 1'b1, 4'd5, 4'd8);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                    d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                    bad++;
                    $display("FAIL up_wrap dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                             k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
                end
            end
        end
    endtask

    task automatic test_rollover();
        logic [3:0] lt_tab [2] = '{4'd0, 4'd2};
        logic [3:0] lo_tab [2] = '{4'd9, 4'd3};
        for (int j = 0; j < 2; j++) begin
            step(1'b0, 1'b1, 1'b1, lt_tab[j], lo_tab[j]);
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
                for (int k = 0; k < NDUT; k++) begin
                    total++;
                    if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                        d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                        bad++;
                        $display("FAIL rollover dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                                 k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] lt_tab [8] = '{4'd6, 4'd1, 4'd6, 4'd0, 4'd10, 4'd9, 4'd0, 4'd15};
        logic [3:0] lo_tab [8] = '{4'd5, 4'd2, 4'd5, 4'd10, 4'd0, 4'd9, 4'd1, 4'd15};
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h < 2; h++) begin
                // Second pass is an idle cycle so load_err must drop after one cycle.
                step(1'b0, 1'b1, (h == 0), lt_tab[i], lo_tab[i]);
                for (int k = 0; k < NDUT; k++) begin
                    total++;
                    if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                        d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                        bad++;
                        $display("FAIL load dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                                 k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b1, 1'b1, 4'd5, 4'd9);
        step(1'b1, 1'b1, 1'b1, 4'd0, 4'd3);
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                bad++;
                $display("FAIL collision dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                         k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
            end
        end
    endtask

    task automatic test_direction();
        step(1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                    d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                    bad++;
                    $display("FAIL direction dut%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                             k, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            bit         e;
            bit         u;
            bit         l;
            logic [3:0] t;
            logic [3:0] o;
            // Opening stretch holds enable with no loads so MODULUS=2 wraps on every other edge.
            e = (i < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            u = (i < 12) ? 1'b1 : 1'($urandom_range(0, 1));
            l = (i < 12) ? 1'b0 : ($urandom_range(0, 7) == 0);
            t = 4'($urandom_range(0, 10));
            o = 4'($urandom_range(0, 10));
            step(e, u, l, t, o);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (d_tens[k] !== 4'(mv[k] / 10) || d_ones[k] !== 4'(mv[k] % 10) || d_carry[k] !== mc[k] ||
                    d_err[k] !== me[k] || snap_term[k] !== exp_term[k]) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got %0d/%0d c%0b e%0b t%0b want %0d c%0b e%0b t%0b",
                             k, i, d_tens[k], d_ones[k], d_carry[k], d_err[k], snap_term[k], mv[k], mc[k], me[k], exp_term[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_rollover();
        test_load();
        test_collision();
        test_direction();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
